// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, TX state encoding and baud divisor helper
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  // Integer truncation: the real baud rate is slightly faster than nominal.
  function automatic int clks_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - show-ahead FIFO with registered occupancy count
module byte_fifo
  import uart_pkg::*;
#(
  parameter int Width = UART_DATA_BITS,
  parameter int Depth = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   push,
  input  logic                   pop,
  input  logic [Width-1:0]       din,
  output logic [Width-1:0]       dout,
  output logic [$clog2(Depth):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AddrW = $clog2(Depth);
  localparam int CntW  = AddrW + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(Depth);

  if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_depth_check
    $error("byte_fifo Depth must be a power of two and at least 2");
  end

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q;
  logic [AddrW-1:0] rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic [CntW-1:0]  count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == FullCount);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AddrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AddrW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - buffered 8N1 UART transmitter fed by the row compressor
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int ClockFreq = 100_000_000,
  parameter int BaudRate  = 115_200,
  parameter int FifoDepth = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [UART_DATA_BITS-1:0] i_frame,
  input  logic                      i_frame_valid,
  output logic                      o_uart_allowed,
  output logic                      o_tx,
  output logic                      o_busy
);

  localparam int ClksPerBit = clks_per_bit(ClockFreq, BaudRate);
  localparam int TimerW     = (ClksPerBit < 2) ? 1 : $clog2(ClksPerBit);
  localparam int CntW       = $clog2(FifoDepth) + 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(ClksPerBit - 1);
  localparam logic [2:0]        LastBit   = 3'(UART_DATA_BITS - 1);

  if (ClksPerBit < 2) begin : g_clks_check
    $error("ClockFreq / BaudRate must be at least 2");
  end

  uart_state_e               state_q;
  logic [TimerW-1:0]         timer_q;
  logic [2:0]                bit_idx_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      tx_q;

  logic [UART_DATA_BITS-1:0] fifo_dout;
  logic [CntW-1:0]           fifo_count;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      push;
  logic                      pop;
  logic                      bit_done;

  assign bit_done       = (timer_q == TimerLast);
  assign push           = i_frame_valid && o_uart_allowed;
  // Popping on the last stop cycle lets the next start bit follow with no idle gap.
  assign pop            = !fifo_empty &&
                          ((state_q == UART_IDLE) || ((state_q == UART_STOP) && bit_done));
  assign o_uart_allowed = !fifo_full;
  assign o_busy         = (state_q != UART_IDLE) || (fifo_count != '0);
  assign o_tx           = tx_q;

  byte_fifo #(
    .Width(UART_DATA_BITS),
    .Depth(FifoDepth)
  ) u_fifo (
    .CLK  (CLK),
    .RST  (RST),
    .push (push),
    .pop  (pop),
    .din  (i_frame),
    .dout (fifo_dout),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // The line level trails the state by one cycle, so every bit still lasts ClksPerBit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= UART_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        UART_START: tx_q <= 1'b0;
        UART_DATA:  tx_q <= shift_q[0];
        default:    tx_q <= 1'b1;
      endcase

      case (state_q)
        UART_IDLE: begin
          if (pop) begin
            shift_q <= fifo_dout;
            timer_q <= '0;
            state_q <= UART_START;
          end
        end
        UART_START: begin
          if (bit_done) begin
            timer_q   <= '0;
            bit_idx_q <= '0;
            state_q   <= UART_DATA;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end
        UART_DATA: begin
          if (bit_done) begin
            timer_q <= '0;
            shift_q <= {1'b0, shift_q[UART_DATA_BITS-1:1]};
            if (bit_idx_q == LastBit) begin
              state_q <= UART_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end
        UART_STOP: begin
          if (bit_done) begin
            timer_q <= '0;
            if (pop) begin
              shift_q <= fifo_dout;
              state_q <= UART_START;
            end else begin
              state_q <= UART_IDLE;
            end
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end
        default: state_q <= UART_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - randomized and directed bench for uart_tx_serializer
module tb_uart_tx_serializer;

  localparam int DEPTH     = 4;
  localparam int BIT_CLKS  = 4;
  localparam int FRAME_LEN = 10 * BIT_CLKS;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] i_frame = 8'h00;
  logic       i_frame_valid = 1'b0;
  logic       o_uart_allowed;
  logic       o_tx;
  logic       o_busy;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_serializer #(
    .ClockFreq(16),
    .BaudRate (4),
    .FifoDepth(DEPTH)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .i_frame       (i_frame),
    .i_frame_valid (i_frame_valid),
    .o_uart_allowed(o_uart_allowed),
    .o_tx          (o_tx),
    .o_busy        (o_busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: a byte queue plus the position (0..39) inside the frame on the wire.
  logic [7:0] mq[$];
  logic [7:0] acc_q[$];
  logic [7:0] rx_q[$];
  bit         m_active = 1'b0;
  int         m_pos = 0;
  int         m_slot = 0;
  logic [7:0] m_cur = 8'h00;
  bit         m_acc = 1'b0;
  logic       exp_tx = 1'b1;
  logic       exp_busy = 1'b0;
  logic       exp_allowed = 1'b1;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mq.delete();
      acc_q.delete();
      m_active    = 1'b0;
      m_pos       = 0;
      exp_tx      = 1'b1;
      exp_busy    = 1'b0;
      exp_allowed = 1'b1;
    end else begin
      m_acc = i_frame_valid && (mq.size() != DEPTH);
      if (m_active) begin
        m_slot = m_pos / BIT_CLKS;
        if (m_slot == 0) exp_tx = 1'b0;
        else if (m_slot == 9) exp_tx = 1'b1;
        else exp_tx = m_cur[m_slot-1];
      end else begin
        exp_tx = 1'b1;
      end
      if (mq.size() != 0 && (!m_active || m_pos == FRAME_LEN - 1)) begin
        m_cur    = mq.pop_front();
        m_active = 1'b1;
        m_pos    = 0;
      end else if (m_active) begin
        if (m_pos == FRAME_LEN - 1) m_active = 1'b0;
        else m_pos++;
      end
      if (m_acc) begin
        mq.push_back(i_frame);
        acc_q.push_back(i_frame);
      end
      exp_busy    = m_active || (mq.size() != 0);
      exp_allowed = (mq.size() != DEPTH);
    end
  end

  always @(negedge CLK) begin
    check("tx", o_tx, exp_tx);
    check("busy", o_busy, exp_busy);
    check("allowed", o_uart_allowed, exp_allowed);
  end

  // Line receiver: decodes frames from o_tx independently of the cycle model.
  bit         mon_on = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = 8'h00;

  always @(negedge CLK) begin
    if (!RST) begin
      mon_on = 1'b0;
      rx_q.delete();
    end else if (!mon_on) begin
      if (!o_tx) begin
        mon_on   = 1'b1;
        mon_cnt  = 1;
        mon_byte = 8'h00;
      end
    end else begin
      if (mon_cnt == 2) check("start_bit", o_tx, 1'b0);
      else if (mon_cnt == FRAME_LEN - 2) check("stop_bit", o_tx, 1'b1);
      else if ((mon_cnt % BIT_CLKS) == 2) mon_byte[mon_cnt/BIT_CLKS-1] = o_tx;
      if (mon_cnt == FRAME_LEN - 1) begin
        mon_on = 1'b0;
        rx_q.push_back(mon_byte);
      end else begin
        mon_cnt++;
      end
    end
  end

  task automatic cyc();
    @(negedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    i_frame_valid = v;
    i_frame       = d;
    cyc();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((o_busy || exp_busy) && n < 2000) begin
      cyc();
      n++;
    end
    check({tag, "_drain"}, 32'(n < 2000), 32'd1);
    repeat (3) cyc();
  endtask

  task automatic clear_logs();
    rx_q.delete();
    acc_q.delete();
  endtask

  task automatic compare_logs(input string tag);
    int n = (rx_q.size() < acc_q.size()) ? rx_q.size() : acc_q.size();
    check({tag, "_nbytes"}, rx_q.size(), acc_q.size());
    for (int i = 0; i < n; i++) check({tag, "_byte"}, rx_q[i], acc_q[i]);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ff_seen;
    int dens;
    repeat (3) cyc();
    RST = 1'b1;
    repeat (6) cyc();
    check("reset_tx", o_tx, 1'b1);
    check("reset_busy", o_busy, 1'b0);
    check("reset_allowed", o_uart_allowed, 1'b1);

    clear_logs();
    drive(1'b1, 8'hA5);
    i_frame_valid = 1'b0;
    check("lat_n0", o_tx, 1'b1);
    cyc();
    check("lat_n1", o_tx, 1'b1);
    cyc();
    check("lat_n2", o_tx, 1'b0);
    wait_idle("single");
    check("single_busy_after", o_busy, 1'b0);
    check("single_n", rx_q.size(), 1);
    if (rx_q.size() == 1) check("single_val", rx_q[0], 8'hA5);

    clear_logs();
    drive(1'b1, 8'h00);
    drive(1'b1, 8'hFF);
    i_frame_valid = 1'b0;
    wait_idle("bound");
    compare_logs("bound");
    if (rx_q.size() == 2) begin
      check("bound_00", rx_q[0], 8'h00);
      check("bound_ff", rx_q[1], 8'hFF);
    end

    clear_logs();
    for (int b = 1; b <= 6; b++) drive(1'b1, 8'(b));
    check("full_drop", o_uart_allowed, 1'b0);
    i_frame_valid = 1'b1;
    i_frame       = 8'hFF;
    n = 0;
    while (!o_uart_allowed && n < 200) begin
      cyc();
      n++;
    end
    check("stall_bound", 32'(n < 200), 32'd1);
    cyc();
    i_frame_valid = 1'b0;
    wait_idle("burst");
    compare_logs("burst");
    check("burst_n", rx_q.size(), 6);
    ff_seen = 0;
    foreach (rx_q[i]) if (rx_q[i] == 8'hFF) ff_seen++;
    check("stall_ff_once", ff_seen, 1);

    clear_logs();
    drive(1'b1, 8'hC3);
    drive(1'b1, 8'h3C);
    i_frame_valid = 1'b0;
    check("pushpop_allowed", o_uart_allowed, 1'b1);
    check("pushpop_busy", o_busy, 1'b1);
    wait_idle("pushpop");
    compare_logs("pushpop");
    if (rx_q.size() == 2) begin
      check("pushpop_first", rx_q[0], 8'hC3);
      check("pushpop_second", rx_q[1], 8'h3C);
    end

    drive(1'b1, 8'h55);
    drive(1'b1, 8'h66);
    drive(1'b0, 8'h00);
    repeat (17) cyc();
    RST = 1'b0;
    #1;
    check("rst_tx", o_tx, 1'b1);
    check("rst_busy", o_busy, 1'b0);
    check("rst_allowed", o_uart_allowed, 1'b1);
    repeat (2) cyc();
    RST = 1'b1;
    repeat (3) cyc();
    clear_logs();
    drive(1'b1, 8'h00);
    i_frame_valid = 1'b0;
    wait_idle("post_rst");
    check("post_rst_n", rx_q.size(), 1);
    if (rx_q.size() == 1) check("post_rst_val", rx_q[0], 8'h00);

    clear_logs();
    dens = 4;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) dens = $urandom_range(0, 8);
      drive(1'($urandom_range(0, 7) < dens), 8'($urandom));
    end
    i_frame_valid = 1'b0;
    wait_idle("rand");
    compare_logs("rand");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Byte-stream UART transmitter for the real-time video link. It sits directly downstream of the row compressor: it accepts compressed bytes over a valid/allowed handshake and buffers them in a small FIFO. It serializes them as 8N1 frames on the FPGA TX pin. The allowed signal feeds the compressor's `i_uart_allowed` input, so the compressor stalls whenever the buffer is full.

## Interface
Parameters:
- `ClockFreq`, 100_000_000, system clock frequency in Hz.
- `BaudRate`, 115_200, line rate in bit/s.
- `FifoDepth`, 4, byte buffer depth; must be a power of two and at least 2.

Ports:
- `CLK`  in  1  system clock; all logic is on the rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `i_frame`  in  8  byte to send; driven by the compressor's `o_frame`.
- `i_frame_valid`  in  1  `i_frame` is valid this cycle; driven by the compressor's `o_uart_ready`.
- `o_uart_allowed`  out  1  buffer can accept a byte; feeds the compressor's `i_uart_allowed`.
- `o_tx`  out  1  serial line; idles high.
- `o_busy`  out  1  a frame is on the line or the FIFO is non-empty.

## Operation
- Derived constant `ClksPerBit = ClockFreq / BaudRate`, using integer truncation.
  - Elaboration fails if `ClksPerBit < 2`.
  - The bit-timer width is `$clog2(ClksPerBit)`.
- Accept rule: a byte is written into the FIFO on any edge where `i_frame_valid && o_uart_allowed`. Bytes offered while `o_uart_allowed` is 0 are ignored, not queued.
- `o_uart_allowed = (count != FifoDepth)`.
  - `count` is a registered value.
  - There is no combinational path from `i_frame_valid` to `o_uart_allowed`.
- FIFO behaviour:
  - Pointers wrap modulo `FifoDepth`.
  - `count` is `$clog2(FifoDepth)+1` bits wide.
  - A push and a pop on the same edge leave `count` unchanged.
- TX FSM states are IDLE, START, DATA, STOP.
  - IDLE: `o_tx`=1. If the FIFO is non-empty, pop into the shift register, clear the bit timer, and go to START.
  - START: `o_tx`=0 for `ClksPerBit` cycles, then go to DATA with bit index 0.
  - DATA: `o_tx`=`shift[0]`, sent LSB first. Each bit lasts `ClksPerBit` cycles, then the register shifts right. After bit index 7 completes, go to STOP.
  - STOP: `o_tx`=1 for `ClksPerBit` cycles. On the last STOP cycle:
    - if the FIFO is non-empty, pop and go straight to START, with no idle gap;
    - otherwise go to IDLE.
- `o_busy = (state != IDLE) || (count != 0)`.
- `o_tx` is driven from a register so the pin never glitches.

## Timing
- Reset values (asynchronous assertion, synchronous-safe deassertion):
  - `o_tx`=1, `o_busy`=0, `o_uart_allowed`=1;
  - state=IDLE, FIFO empty, pointers 0, timer 0.
- Latency: for a byte accepted at edge N with the FIFO empty and the FSM in IDLE, the pop happens at edge N+1 and `o_tx` falls at edge N+2.
- Frame length is exactly `10*ClksPerBit` cycles. Back-to-back frames are spaced at exactly this period.
- Full boundary:
  - The push that fills the FIFO drives `o_uart_allowed` low from the next cycle.
  - A pop raises it again the cycle after the pop.
- Empty boundary: a push into an empty FIFO during the last STOP cycle is not popped that cycle. The FSM goes to IDLE and pops one cycle later, leaving one idle-high cycle.
- Reset mid-frame:
  - `o_tx` returns to 1 immediately and the FIFO is flushed.
  - After release, no partial frame resumes.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding (`UART_IDLE`, `UART_START`, `UART_DATA`, `UART_STOP`);
  - `UART_DATA_BITS`=8;
  - the `ClksPerBit` calculation function.
- Sub-module `byte_fifo`:
  - parameters: `Width` and `Depth`;
  - ports: `CLK`, `RST`, push, pop, din, dout, count, full, empty;
  - dout is show-ahead, valid whenever empty=0.
- Top level: the FSM, bit timer, and shift register.

## Test plan
Bench parameters: `ClockFreq`=16, `BaudRate`=4, so `ClksPerBit`=4.
1. Single byte: push 0xA5 at edge 10, then idle → `o_tx` falls at edge 12. The line then carries 0, 1,0,1,0,0,1,0,1, 1, each held 4 cycles, for 40 cycles total. `o_busy` is 0 afterwards.
2. Burst to full with `FifoDepth`=4: hold `i_frame_valid`=1 with bytes 0x01..0x06 → `o_uart_allowed` drops after the FIFO fills. Only the accepted bytes are transmitted, in order, back-to-back with 40-cycle spacing and no idle gap.
3. Stall compliance: offer 0xFF while `o_uart_allowed`=0 → 0xFF never appears on `o_tx`. Offer it again once allowed rises → it is sent exactly once.
4. Simultaneous push/pop: push 0x3C in the same cycle that IDLE pops 0xC3 → `count` is unchanged. 0xC3 is sent, then 0x3C.
5. Reset mid-frame: assert `RST` low during DATA bit 3 → `o_tx`=1, `o_busy`=0, and `o_uart_allowed`=1 immediately. After release, pushing 0x00 yields a clean, full frame.
6. Boundary bytes: send 0x00 and then 0xFF → verify the start and stop bits, LSB-first order, and that every bit lasts exactly 4 cycles.
